ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage multiply/divide and HI/LO-write engine. It consumes the mul_div_bus
//  {div,divu,mult,multu,mtlo,mthi} and the rs/rt operands that decode hands to
//  execute. It computes HI/LO results over one or more cycles, requests a pipeline
//  stall while busy, and drives the HI/LO write bus forwarded to MEM/WB.
// PARAMETERS
//  DIV_CYCLES  32  radix-2 restoring-divide iterations; one quotient bit per cycle
//  STALL_W     6   width of the stall vector (StallBus); the EX bit is stall[3]
// PORTS
//  clk         in   1   system clock; everything samples on the rising edge
//  rst         in   1   asynchronous, active-high reset
//  stall       in   6   pipeline stall vector; stall[3]=EX held, stall[4]=MEM held
//  valid_i     in   1   an instruction currently occupies EX (0 = bubble)
//  mul_div_i   in   6   {div,divu,mult,multu,mtlo,mthi}
//  src_a_i     in   32  rs value (dividend / multiplicand / mthi/mtlo source)
//  src_b_i     in   32  rt value (divisor / multiplier)
//  stallreq_o  out  1   stall request to the stall controller while computing
//  hilo_we_o   out  2   {hi_we, lo_we}
//  hi_o        out  32  HI write data
//  lo_o        out  32  LO write data
//  busy_o      out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, count=0. stallreq_o=0, hilo_we_o=0, hi_o=lo_o=0,
//   busy_o=0. Reset mid-operation abandons the computation immediately.
//  Decode priority when several bits are set: div > divu > mult > multu > mtlo > mthi.
//   An op starts only when valid_i=1 and state=IDLE.
//  FSM states: IDLE, DIV_RUN, MUL_RUN, DONE.
//  IDLE + div/divu:
//   - latch |a| and |b| (raw values for divu) and sign_q=a31^b31, sign_r=a31 (div only)
//   - go to DIV_RUN with count=0; stallreq_o=1 combinationally in this cycle
//  DIV_RUN: one shift-subtract step per cycle, count+1. After DIV_CYCLES steps
//   (count wraps 31->0), go to DONE. stallreq_o=1 throughout.
//  IDLE + mult/multu: register the 64-bit product (signed or unsigned) and go to
//   MUL_RUN; stallreq_o=1. MUL_RUN->DONE next cycle with stallreq_o=1.
//  DONE:
//   - stallreq_o=0, hilo_we_o=2'b11, hi_o/lo_o = remainder/quotient (div) or
//     product[63:32]/[31:0] (mult)
//   - stays in DONE while stall[3]=Stop (downstream hold); outputs held, repeat
//     writes are harmless
//   - goes to IDLE on the first cycle with stall[3]=NoStop
//  Latency: div stalls 1+32+1 = 34 cycles, result in the 35th cycle; mult stalls
//   2 cycles, result in the 3rd cycle.
//  mtlo/mthi in IDLE: single cycle, no stall. hilo_we_o=01/10, the written half =
//   src_a_i, the other half holds its old value. Combinational in that cycle only.
//  Outside DONE and mt*: hilo_we_o=0; hi_o/lo_o hold their last value.
//  Signed correction in DONE: q = sign_q ? -q : q; r = sign_r ? -r : r.
//  Divide by zero: lo = 32'hFFFF_FFFF, hi = dividend (raw src_a). Same timing, no
//   exception.
//  Signed overflow 0x8000_0000 / -1: lo = 0x8000_0000, hi = 0.
//  Inputs are sampled only at start; changes during RUN states are ignored.
//  valid_i=0 or mul_div_i=0 in IDLE: no action, outputs idle.
// TESTING
//  1 divu 100/7 -> stallreq_o=1 for 34 cycles, then one cycle hilo_we=11, hi=2, lo=14
//  2 div -7/2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); div 0x8000_0000/-1 -> lo=0x8000_0000, hi=0
//  3 divu 5/0 -> lo=0xFFFF_FFFF, hi=5, same 34-cycle stall
//  4 mult 0xFFFF_FFFF*2 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFFE; multu same -> hi=1, lo=0xFFFF_FFFE; 2-cycle stall
//  5 mthi 0x1234 -> same cycle hilo_we=10, hi_o=0x1234, stallreq_o=0; then mtlo 0x55 -> we=01, lo_o=0x55
//  6 rst at DIV_RUN count=10 -> same cycle stallreq/busy=0, outputs 0; divu with stall[3]=1 in DONE for 3 cycles -> we=11 held 4 cycles, then IDLE

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage multiply/divide bus: decode/operands toward the unit, HI/LO write and stall back.
interface ex_muldiv_unit_if #(
   parameter int unsigned STALL_W = 6
);
   logic [STALL_W-1:0] stall;
   logic               valid_i;
   logic [5:0]         mul_div_i;
   logic [31:0]        src_a_i;
   logic [31:0]        src_b_i;
   logic               stallreq_o;
   logic [1:0]         hilo_we_o;
   logic [31:0]        hi_o;
   logic [31:0]        lo_o;
   logic               busy_o;

   modport master (
      output stall, valid_i, mul_div_i, src_a_i, src_b_i,
      input  stallreq_o, hilo_we_o, hi_o, lo_o, busy_o
   );

   modport slave (
      input  stall, valid_i, mul_div_i, src_a_i, src_b_i,
      output stallreq_o, hilo_we_o, hi_o, lo_o, busy_o
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply / restoring-divide engine with mthi/mtlo and HI/LO write bus.
module ex_muldiv_unit #(
   parameter int unsigned DIV_CYCLES = 32
) (
   input logic             clk,
   input logic             rst,
   ex_muldiv_unit_if.slave bus
);
   localparam int unsigned   CW        = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DIV_RUN, MUL_RUN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          steps_done;
   logic [31:0]   quo_q, rem_q, dsr_q, dvd_raw_q, hi_q, lo_q;
   logic [63:0]   prod_q;
   logic          sign_q, sign_r, div0_q;

   logic          op_div, op_divu, op_mult, op_multu, op_mtlo, op_mthi;
   logic [31:0]   a_abs, b_abs, rem_sub, q_fix, r_fix;
   logic [32:0]   rem_sh;
   logic          take;
   logic [63:0]   prod_s, prod_u;

   always_comb begin
      op_div   = 1'b0;
      op_divu  = 1'b0;
      op_mult  = 1'b0;
      op_multu = 1'b0;
      op_mtlo  = 1'b0;
      op_mthi  = 1'b0;
      if (bus.valid_i && state == IDLE) begin
         if (bus.mul_div_i[5])      op_div   = 1'b1;
         else if (bus.mul_div_i[4]) op_divu  = 1'b1;
         else if (bus.mul_div_i[3]) op_mult  = 1'b1;
         else if (bus.mul_div_i[2]) op_multu = 1'b1;
         else if (bus.mul_div_i[1]) op_mtlo  = 1'b1;
         else if (bus.mul_div_i[0]) op_mthi  = 1'b1;
      end
   end

   assign a_abs  = (op_div && bus.src_a_i[31]) ? (~bus.src_a_i + 32'd1) : bus.src_a_i;
   assign b_abs  = (op_div && bus.src_b_i[31]) ? (~bus.src_b_i + 32'd1) : bus.src_b_i;
   assign prod_s = {{32{bus.src_a_i[31]}}, bus.src_a_i} * {{32{bus.src_b_i[31]}}, bus.src_b_i};
   assign prod_u = {32'd0, bus.src_a_i} * {32'd0, bus.src_b_i};

   // Quotient shifts in from the bottom of quo_q while dividend bits shift out the top.
   assign rem_sh  = {rem_q, quo_q[31]};
   assign take    = (rem_sh >= {1'b0, dsr_q});
   assign rem_sub = rem_sh[31:0] - dsr_q;
   assign q_fix   = sign_q ? (~quo_q + 32'd1) : quo_q;
   assign r_fix   = sign_r ? (~rem_q + 32'd1) : rem_q;

   // Start terms are combinational in the IDLE cycle, so reset must mask them too.
   assign bus.busy_o     = (state != IDLE);
   assign bus.stallreq_o = !rst && (op_div || op_divu || op_mult || op_multu ||
                                    state == DIV_RUN || state == MUL_RUN);
   assign bus.hilo_we_o  = rst ? 2'b00 : (state == DONE) ? 2'b11 : {op_mthi, op_mtlo};
   assign bus.hi_o       = (!rst && op_mthi) ? bus.src_a_i : hi_q;
   assign bus.lo_o       = (!rst && op_mtlo) ? bus.src_a_i : lo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         steps_done <= 1'b0;
         quo_q      <= '0;
         rem_q      <= '0;
         dsr_q      <= '0;
         dvd_raw_q  <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         prod_q     <= '0;
         sign_q     <= 1'b0;
         sign_r     <= 1'b0;
         div0_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (op_div || op_divu) begin
                  quo_q      <= a_abs;
                  rem_q      <= '0;
                  dsr_q      <= b_abs;
                  dvd_raw_q  <= bus.src_a_i;
                  div0_q     <= (bus.src_b_i == '0);
                  sign_q     <= op_div && (bus.src_a_i[31] ^ bus.src_b_i[31]);
                  sign_r     <= op_div && bus.src_a_i[31];
                  count      <= '0;
                  steps_done <= 1'b0;
                  state      <= DIV_RUN;
               end else if (op_mult || op_multu) begin
                  prod_q <= op_mult ? prod_s : prod_u;
                  state  <= MUL_RUN;
               end else if (op_mtlo) begin
                  lo_q <= bus.src_a_i;
               end else if (op_mthi) begin
                  hi_q <= bus.src_a_i;
               end
            end
            DIV_RUN: begin
               if (!steps_done) begin
                  rem_q <= take ? rem_sub : rem_sh[31:0];
                  quo_q <= {quo_q[30:0], take};
                  count <= (count == LAST_STEP) ? '0 : count + CW'(1);
                  if (count == LAST_STEP) steps_done <= 1'b1;
               end else begin
                  // Sign fix-up / divide-by-zero override costs one extra stall cycle.
                  hi_q       <= div0_q ? dvd_raw_q : r_fix;
                  lo_q       <= div0_q ? '1 : q_fix;
                  steps_done <= 1'b0;
                  state      <= DONE;
               end
            end
            MUL_RUN: begin
               hi_q  <= prod_q[63:32];
               lo_q  <= prod_q[31:0];
               state <= DONE;
            end
            DONE: begin
               if (!bus.stall[3]) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic HI/LO reference.
module tb_ex_muldiv_unit;
   logic clk = 1'b0;
   logic rst;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] hi_m, lo_m;

   localparam logic [5:0] OP_DIV   = 6'b100000;
   localparam logic [5:0] OP_DIVU  = 6'b010000;
   localparam logic [5:0] OP_MULT  = 6'b001000;
   localparam logic [5:0] OP_MULTU = 6'b000100;
   localparam logic [5:0] OP_MTLO  = 6'b000010;
   localparam logic [5:0] OP_MTHI  = 6'b000001;

   ex_muldiv_unit_if #(.STALL_W(6)) bus ();

   ex_muldiv_unit #(.DIV_CYCLES(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: highest set op bit wins; results from plain integer arithmetic.
   function automatic logic [63:0] ref_hilo(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi_old,
                                            input logic [31:0] lo_old);
      int top = -1;
      int sa = a;
      int sb = b;
      longint sp;
      longint unsigned ua = a;
      longint unsigned ub = b;
      for (int i = 5; i >= 0; i--) if (op[i] && top < 0) top = i;
      case (top)
         5: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {sa % sb, sa / sb};
         end
         4: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         3: begin
            sp = longint'(sa) * longint'(sb);
            return sp;
         end
         2: return ua * ub;
         1: return {hi_old, a};
         0: return {a, lo_old};
         default: return {hi_old, lo_old};
      endcase
   endfunction

   task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned hold,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int unsigned exp_stall);
      int unsigned n = 0;
      bus.valid_i = 1'b1;
      bus.mul_div_i = op;
      bus.src_a_i = a;
      bus.src_b_i = b;
      #1;
      while (bus.stallreq_o && n < 100) begin
         n++;
         @(negedge clk); #1;
         if (n == 1) begin
            bus.src_a_i = $urandom;
            bus.src_b_i = $urandom;
            bus.mul_div_i = 6'($urandom);
         end
      end
      check_eq({tag, "_stall_len"}, 64'(n), 64'(exp_stall));
      for (int unsigned i = 0; i <= hold; i++) begin
         check_eq({tag, "_we"}, 64'(bus.hilo_we_o), 64'(2'b11));
         check_eq({tag, "_hi"}, 64'(bus.hi_o), 64'(exp_hi));
         check_eq({tag, "_lo"}, 64'(bus.lo_o), 64'(exp_lo));
         if (i == 0) check_eq({tag, "_busy_done"}, 64'(bus.busy_o), 64'd1);
         bus.stall[3] = (i < hold);
         if (i == hold) bus.valid_i = 1'b0;
         @(negedge clk); #1;
      end
      bus.stall = '0;
      check_eq({tag, "_we_after"}, 64'(bus.hilo_we_o), 64'd0);
      check_eq({tag, "_busy_after"}, 64'(bus.busy_o), 64'd0);
      check_eq({tag, "_hold_hilo"}, {bus.hi_o, bus.lo_o}, {exp_hi, exp_lo});
      hi_m = exp_hi;
      lo_m = exp_lo;
   endtask

   task automatic do_mt(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [1:0] exp_we, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
      bus.valid_i = 1'b1;
      bus.mul_div_i = op;
      bus.src_a_i = a;
      bus.src_b_i = $urandom;
      #1;
      check_eq({tag, "_we"}, 64'(bus.hilo_we_o), 64'(exp_we));
      check_eq({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, {exp_hi, exp_lo});
      check_eq({tag, "_nostall"}, 64'(bus.stallreq_o), 64'd0);
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      check_eq({tag, "_we_after"}, 64'(bus.hilo_we_o), 64'd0);
      check_eq({tag, "_hold_hilo"}, {bus.hi_o, bus.lo_o}, {exp_hi, exp_lo});
      hi_m = exp_hi;
      lo_m = exp_lo;
   endtask

   task automatic do_bubble(input logic v, input logic [5:0] md);
      bus.valid_i = v;
      bus.mul_div_i = md;
      bus.src_a_i = $urandom;
      #1;
      check_eq("bubble_we", 64'(bus.hilo_we_o), 64'd0);
      check_eq("bubble_stall", 64'(bus.stallreq_o), 64'd0);
      @(negedge clk); #1;
      check_eq("bubble_busy", 64'(bus.busy_o), 64'd0);
      check_eq("bubble_hilo", {bus.hi_o, bus.lo_o}, {hi_m, lo_m});
      bus.valid_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  op;
      logic [31:0] a, b;
      logic [63:0] r;
      rst = 1'b1;
      bus.stall = '0;
      bus.valid_i = 1'b0;
      bus.mul_div_i = '0;
      bus.src_a_i = '0;
      bus.src_b_i = '0;
      hi_m = '0;
      lo_m = '0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset_outputs",
               {bus.hi_o, bus.lo_o, 30'd0, bus.hilo_we_o, 30'd0, bus.stallreq_o, bus.busy_o},
               '0);
      rst = 1'b0;
      @(negedge clk); #1;

      do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0, 32'd2, 32'd14, 34);
      do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
      do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 32'h8000_0000, 34);
      do_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 0, 32'd5, 32'hFFFF_FFFF, 34);
      do_op("div_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 34);
      do_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
      do_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 32'd1, 32'hFFFF_FFFE, 2);
      do_mt("mthi", OP_MTHI, 32'h1234, 2'b10, 32'h1234, 32'hFFFF_FFFE);
      do_mt("mtlo", OP_MTLO, 32'h55, 2'b01, 32'h1234, 32'h55);
      do_op("prio_div", 6'b111111, 32'd100, 32'd7, 0, 32'd2, 32'd14, 34);
      do_mt("prio_mtlo", 6'b000011, 32'hCAFE, 2'b01, 32'd2, 32'hCAFE);
      do_bubble(1'b0, OP_DIV);
      do_bubble(1'b1, 6'd0);

      // Asynchronous reset in the middle of a divide.
      bus.valid_i = 1'b1;
      bus.mul_div_i = OP_DIVU;
      bus.src_a_i = 32'd1000;
      bus.src_b_i = 32'd3;
      repeat (11) @(negedge clk);
      #1;
      check_eq("pre_rst_busy", 64'(bus.busy_o), 64'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_div",
               {bus.hi_o, bus.lo_o, 30'd0, bus.hilo_we_o, 30'd0, bus.stallreq_o, bus.busy_o},
               '0);
      bus.valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      hi_m = '0;
      lo_m = '0;
      check_eq("post_rst_idle", 64'({bus.busy_o, bus.stallreq_o, bus.hilo_we_o}), 64'd0);

      do_op("divu_hold3", OP_DIVU, 32'd1000, 32'd33, 3, 32'd10, 32'd30, 34);

      for (int k = 0; k < 24; k++) begin
         op = 6'($urandom_range(1, 63));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = b & 32'hFF;
            default: ;
         endcase
         r = ref_hilo(op, a, b, hi_m, lo_m);
         if (op[5:2] != 4'd0)
            do_op("rand_op", op, a, b, $urandom_range(0, 2), r[63:32], r[31:0],
                  (op[5] || op[4]) ? 34 : 2);
         else
            do_mt("rand_mt", op, a, op[1] ? 2'b01 : 2'b10, r[63:32], r[31:0]);
         if (k % 4 == 0) do_bubble(1'b0, 6'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
